ptw_req_arbiter: RTL and testbench

//  Shares the single page table walker (ptw) between the instruction TLB and the data TLB.

---
 rtl/ptw_arb_pkg.sv | 7 +
 rtl/ptw_arb_rr2.sv | 15 +
 rtl/ptw_req_arbiter.sv | 87 ++++++++
 tb/tb_ptw_req_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ptw_arb_pkg.sv
// ptw_arb_pkg: FSM states, owner masks and VPN position shared by the ptw request arbiter
package ptw_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;
  localparam logic [1:0] OWN_I = 2'b01;
  localparam logic [1:0] OWN_D = 2'b10;
  localparam int VPN_LSB = 12;
endpackage

// File: rtl/ptw_arb_rr2.sv
// ptw_arb_rr2: 2-way round-robin picker (bit0 itlb, bit1 dtlb); pointer moves only on contested grants
module ptw_arb_rr2
  import ptw_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       prio,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       ptr_next
);
  always_comb begin
    grant = (&valid) ? ((prio || ptr) ? OWN_D : OWN_I) : valid;
    ptr_next = (&valid) ? grant[0] : ptr;
  end
endmodule

// File: rtl/ptw_req_arbiter.sv
// ptw_req_arbiter: shares one page table walker between itlb and dtlb, round-robin, same-VPN merge
module ptw_req_arbiter
  import ptw_arb_pkg::*;
#(
  parameter int VA_W      = 32,
  parameter int PTE_W     = 32,
  parameter bit DTLB_PRIO = 1'b0,
  parameter bit MERGE_EN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             itlb_req_valid_i,
  output logic             itlb_req_ready_o,
  input  logic [VA_W-1:0]  itlb_vaddr_i,
  output logic             itlb_resp_valid_o,
  input  logic             itlb_resp_ready_i,
  output logic [PTE_W-1:0] itlb_pte_o,
  input  logic             dtlb_req_valid_i,
  output logic             dtlb_req_ready_o,
  input  logic [VA_W-1:0]  dtlb_vaddr_i,
  output logic             dtlb_resp_valid_o,
  input  logic             dtlb_resp_ready_i,
  output logic [PTE_W-1:0] dtlb_pte_o,
  output logic             ptw_req_valid_o,
  input  logic             ptw_req_ready_i,
  output logic [VA_W-1:0]  ptw_vaddr_o,
  input  logic             ptw_resp_valid_i,
  output logic             ptw_resp_ready_o,
  input  logic [PTE_W-1:0] ptw_pte_i,
  output logic             busy_o
);
  state_t state, state_next;
  logic ptr, rr_ptr, same, accept;
  logic [1:0] req, grant, ready, own, own_next;
  logic [VA_W-1:0] vaddr;
  logic [PTE_W-1:0] pte;
  assign req = {dtlb_req_valid_i, itlb_req_valid_i};
  assign same = MERGE_EN && (&req) && (itlb_vaddr_i[VA_W-1:VPN_LSB] == dtlb_vaddr_i[VA_W-1:VPN_LSB]);
  assign ready = (state == IDLE && rst) ? (same ? 2'b11 : grant) : 2'b00;
  assign accept = |ready;
  assign own_next = own & ~{dtlb_resp_ready_i, itlb_resp_ready_i};
  ptw_arb_rr2 u_rr (
    .valid    (req),
    .prio     (DTLB_PRIO),
    .ptr      (ptr),
    .grant    (grant),
    .ptr_next (rr_ptr)
  );
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = accept ? ISSUE : IDLE;
      ISSUE:   state_next = ptw_req_ready_i ? WAIT : ISSUE;
      WAIT:    state_next = ptw_resp_valid_i ? DELIVER : WAIT;
      DELIVER: state_next = (own_next == 2'b00) ? IDLE : DELIVER;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ptr <= 1'b0;
      vaddr <= '0;
      own <= 2'b00;
      pte <= '0;
    end else begin
      if (accept) begin
        vaddr <= grant[1] ? dtlb_vaddr_i : itlb_vaddr_i;
        own <= ready;
        ptr <= same ? ptr : rr_ptr;
      end else if (state == DELIVER) own <= own_next;
      if (state == WAIT && ptw_resp_valid_i) pte <= ptw_pte_i;
    end
  assign itlb_req_ready_o = ready[0];
  assign dtlb_req_ready_o = ready[1];
  assign itlb_resp_valid_o = state == DELIVER && own[0];
  assign dtlb_resp_valid_o = state == DELIVER && own[1];
  assign itlb_pte_o = pte;
  assign dtlb_pte_o = pte;
  assign ptw_req_valid_o = state == ISSUE;
  assign ptw_vaddr_o = vaddr;
  assign ptw_resp_ready_o = state == WAIT;
  assign busy_o = state != IDLE;
  a_resp_in_wait: assert property (@(posedge clk) disable iff (!rst) ptw_resp_valid_i |-> state == WAIT);
endmodule

// File: tb/tb_ptw_req_arbiter.sv
// tb_ptw_req_arbiter: directed checks of arbitration, merge, backpressure and reset
module tb_ptw_req_arbiter;
  logic clk = 0, rst = 0;
  logic itlb_req_valid_i = 0, itlb_req_ready_o, itlb_resp_valid_o, itlb_resp_ready_i = 0;
  logic dtlb_req_valid_i = 0, dtlb_req_ready_o, dtlb_resp_valid_o, dtlb_resp_ready_i = 0;
  logic [31:0] itlb_vaddr_i = 0, dtlb_vaddr_i = 0, itlb_pte_o, dtlb_pte_o;
  logic ptw_req_valid_o, ptw_req_ready_i = 0, ptw_resp_valid_i = 0, ptw_resp_ready_o, busy_o;
  logic [31:0] ptw_vaddr_o, ptw_pte_i = 0;
  int checks = 0, errors = 0, hs = 0, hs0;
  ptw_req_arbiter dut (
    .clk(clk), .rst(rst),
    .itlb_req_valid_i(itlb_req_valid_i), .itlb_req_ready_o(itlb_req_ready_o), .itlb_vaddr_i(itlb_vaddr_i),
    .itlb_resp_valid_o(itlb_resp_valid_o), .itlb_resp_ready_i(itlb_resp_ready_i), .itlb_pte_o(itlb_pte_o),
    .dtlb_req_valid_i(dtlb_req_valid_i), .dtlb_req_ready_o(dtlb_req_ready_o), .dtlb_vaddr_i(dtlb_vaddr_i),
    .dtlb_resp_valid_o(dtlb_resp_valid_o), .dtlb_resp_ready_i(dtlb_resp_ready_i), .dtlb_pte_o(dtlb_pte_o),
    .ptw_req_valid_o(ptw_req_valid_o), .ptw_req_ready_i(ptw_req_ready_i), .ptw_vaddr_o(ptw_vaddr_o),
    .ptw_resp_valid_i(ptw_resp_valid_i), .ptw_resp_ready_o(ptw_resp_ready_o), .ptw_pte_i(ptw_pte_i),
    .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (rst && ptw_req_valid_o && ptw_req_ready_i) hs <= hs + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #2;
  endtask
  task automatic all_zero(input string tag);
    chk({tag, "_out"}, {30'd0, itlb_req_ready_o, dtlb_req_ready_o} | {itlb_resp_valid_o, dtlb_resp_valid_o,
        ptw_req_valid_o, ptw_resp_ready_o, busy_o}, 32'd0);
    chk({tag, "_vaddr"}, ptw_vaddr_o, 32'd0);
    chk({tag, "_pte"}, itlb_pte_o | dtlb_pte_o, 32'd0);
  endtask
  task automatic walk(input logic [31:0] va, input logic [31:0] pte, input int stall, input int delay);
    for (int i = 0; i < stall; i++) begin
      chk("issue_valid", ptw_req_valid_o, 1);
      chk("issue_vaddr", ptw_vaddr_o, va);
      chk("no_accept_issue", {itlb_req_ready_o, dtlb_req_ready_o}, 0);
      cyc;
    end
    chk("issue_valid", ptw_req_valid_o, 1);
    chk("issue_vaddr", ptw_vaddr_o, va);
    ptw_req_ready_i = 1;
    cyc;
    ptw_req_ready_i = 0;
    chk("issue_done", ptw_req_valid_o, 0);
    for (int i = 0; i < delay; i++) begin
      chk("wait_ready", ptw_resp_ready_o, 1);
      chk("no_accept_wait", {itlb_req_ready_o, dtlb_req_ready_o, busy_o}, 1);
      cyc;
    end
    chk("wait_ready", ptw_resp_ready_o, 1);
    ptw_resp_valid_i = 1;
    ptw_pte_i = pte;
    cyc;
    ptw_resp_valid_i = 0;
    ptw_pte_i = 0;
  endtask
  task automatic deliver(input logic [1:0] own, input logic [31:0] pte);
    chk("resp_valid", {dtlb_resp_valid_o, itlb_resp_valid_o}, own);
    if (own[0]) chk("itlb_pte", itlb_pte_o, pte);
    if (own[1]) chk("dtlb_pte", dtlb_pte_o, pte);
    itlb_resp_ready_i = 1;
    dtlb_resp_ready_i = 1;
    cyc;
    itlb_resp_ready_i = 0;
    dtlb_resp_ready_i = 0;
    chk("deliver_done", {dtlb_resp_valid_o, itlb_resp_valid_o, busy_o}, 0);
  endtask
  initial begin
    // 1 reset
    itlb_req_valid_i = 1;
    cyc;
    chk("rst_ready_gated", itlb_req_ready_o, 0);
    itlb_req_valid_i = 0;
    cyc;
    all_zero("in_rst");
    rst = 1;
    cyc;
    all_zero("post_rst");
    itlb_vaddr_i = 32'h0000_0000;
    itlb_req_valid_i = 1;
    #1;
    chk("rst_itlb_ready", {itlb_req_ready_o, dtlb_req_ready_o}, 2'b10);
    // 2 single itlb walk
    hs0 = hs;
    cyc;
    itlb_req_valid_i = 0;
    chk("t2_busy", busy_o, 1);
    walk(32'h0000_0000, 32'h1000_000F, 0, 0);
    chk("t2_dtlb_quiet", dtlb_resp_valid_o, 0);
    deliver(2'b01, 32'h1000_000F);
    chk("t2_one_walk", hs - hs0, 1);
    // 3 contested pair, rr pointer at itlb
    itlb_vaddr_i = 32'h0000_1000;
    dtlb_vaddr_i = 32'h0040_0000;
    itlb_req_valid_i = 1;
    dtlb_req_valid_i = 1;
    #1;
    chk("t3_itlb_wins", {itlb_req_ready_o, dtlb_req_ready_o}, 2'b10);
    cyc;
    itlb_req_valid_i = 0;
    walk(32'h0000_1000, 32'h1100_000F, 0, 0);
    deliver(2'b01, 32'h1100_000F);
    chk("t3_dtlb_next", {itlb_req_ready_o, dtlb_req_ready_o}, 2'b01);
    cyc;
    dtlb_req_valid_i = 0;
    walk(32'h0040_0000, 32'h2000_000F, 0, 0);
    deliver(2'b10, 32'h2000_000F);
    itlb_vaddr_i = 32'h0000_0000;
    itlb_req_valid_i = 1;
    dtlb_req_valid_i = 1;
    #1;
    chk("t3_third_dtlb", {itlb_req_ready_o, dtlb_req_ready_o}, 2'b01);
    cyc;
    itlb_req_valid_i = 0;
    dtlb_req_valid_i = 0;
    walk(32'h0040_0000, 32'h2000_000F, 0, 1);
    deliver(2'b10, 32'h2000_000F);
    chk("t3_dropped_itlb", busy_o, 0);
    // 4 merge on equal VPN, dtlb slow to ack
    hs0 = hs;
    itlb_vaddr_i = 32'h0000_1000;
    dtlb_vaddr_i = 32'h0000_1000;
    itlb_req_valid_i = 1;
    dtlb_req_valid_i = 1;
    #1;
    chk("t4_both_ready", {itlb_req_ready_o, dtlb_req_ready_o}, 2'b11);
    cyc;
    itlb_req_valid_i = 0;
    dtlb_req_valid_i = 0;
    walk(32'h0000_1000, 32'h1100_000F, 0, 0);
    chk("t4_both_valid", {dtlb_resp_valid_o, itlb_resp_valid_o}, 2'b11);
    chk("t4_itlb_pte", itlb_pte_o, 32'h1100_000F);
    chk("t4_dtlb_pte", dtlb_pte_o, 32'h1100_000F);
    itlb_resp_ready_i = 1;
    cyc;
    itlb_resp_ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t4_dtlb_pending", {itlb_resp_valid_o, dtlb_resp_valid_o, busy_o}, 3'b011);
      chk("t4_dtlb_pte_hold", dtlb_pte_o, 32'h1100_000F);
      cyc;
    end
    deliver(2'b10, 32'h1100_000F);
    chk("t4_one_walk", hs - hs0, 1);
    // 5 backpressure with a dtlb request waiting
    itlb_vaddr_i = 32'h0000_0000;
    dtlb_vaddr_i = 32'h0040_0000;
    itlb_req_valid_i = 1;
    #1;
    chk("t5_itlb_ready", {itlb_req_ready_o, dtlb_req_ready_o}, 2'b10);
    cyc;
    itlb_req_valid_i = 0;
    dtlb_req_valid_i = 1;
    walk(32'h0000_0000, 32'h1000_000F, 4, 6);
    chk("t5_dtlb_blocked", dtlb_req_ready_o, 0);
    deliver(2'b01, 32'h1000_000F);
    chk("t5_dtlb_ready", dtlb_req_ready_o, 1);
    cyc;
    dtlb_req_valid_i = 0;
    walk(32'h0040_0000, 32'h2000_000F, 0, 0);
    deliver(2'b10, 32'h2000_000F);
    // 6 reset during WAIT
    dtlb_req_valid_i = 1;
    cyc;
    dtlb_req_valid_i = 0;
    ptw_req_ready_i = 1;
    cyc;
    ptw_req_ready_i = 0;
    chk("t6_in_wait", {busy_o, ptw_resp_ready_o}, 2'b11);
    rst = 0;
    #1;
    all_zero("t6_rst");
    cyc;
    rst = 1;
    cyc;
    all_zero("t6_post");
    dtlb_req_valid_i = 1;
    #1;
    chk("t6_dtlb_ready", dtlb_req_ready_o, 1);
    cyc;
    dtlb_req_valid_i = 0;
    walk(32'h0040_0000, 32'h2000_000F, 0, 2);
    deliver(2'b10, 32'h2000_000F);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
